// File: rtl/pad_feedback_tx.sv
// Serial status-frame transmitter to the two controller pads (shared SCLK/LATCH, per-pad DATA).
// Defining PAD_TX_PARITY_EN appends an odd-parity bit to each frame (17 bits instead of 16).
module pad_feedback_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_send,
  input  logic [1:0] i_state,
  input  logic [1:0] i_who_wins,
  input  logic [4:0] i_p1_shell,
  input  logic [4:0] i_p2_shell,
  input  logic [4:0] i_p1_led,
  input  logic [4:0] i_p2_led,
  output logic       o_sclk,
  output logic       o_sdata_1,
  output logic       o_sdata_2,
  output logic       o_latch,
  output logic       o_busy,
  output logic [2:0] o_seq
);

`ifdef PAD_TX_PARITY_EN
  localparam int unsigned NBITS = 17;
`else
  localparam int unsigned NBITS = 16;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(NBITS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StShiftLo, StShiftHi, StLatch} state_e;

  state_e             state_q;
  logic [7:0]         div_q;
  logic [4:0]         bit_cnt_q;
  logic [2:0]         seq_q;
  logic               pending_q;
  logic [NBITS-1:0]   sr1_q, sr2_q;
  logic [15:0]        base1, base2;
  logic [NBITS-1:0]   frame1, frame2;
  logic               div_done;

  always_comb begin
    base1 = {i_state, i_who_wins[0], i_p1_shell, seq_q, i_p1_led};
    base2 = {i_state, i_who_wins[1], i_p2_shell, seq_q, i_p2_led};
`ifdef PAD_TX_PARITY_EN
    frame1 = {base1, ~^base1};
    frame2 = {base2, ~^base2};
`else
    frame1 = base1;
    frame2 = base2;
`endif
  end

  assign div_done = (div_q == DIV_LAST);

  // Outputs are registered alongside the state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      o_sclk    <= 1'b0;
      o_sdata_1 <= 1'b0;
      o_sdata_2 <= 1'b0;
      o_latch   <= 1'b0;
      o_busy    <= 1'b0;
      o_seq     <= '0;
    end else begin
      // One-deep request capture while a frame is in flight, including the final LATCH cycle.
      if (state_q != StIdle && i_send) pending_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (i_send || pending_q) begin
            state_q   <= StLoad;
            pending_q <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        StLoad: begin
          sr1_q     <= frame1;
          sr2_q     <= frame2;
          bit_cnt_q <= '0;
          div_q     <= '0;
          o_sdata_1 <= frame1[NBITS-1];
          o_sdata_2 <= frame2[NBITS-1];
          state_q   <= StShiftLo;
        end
        StShiftLo: begin
          if (div_done) begin
            div_q   <= '0;
            o_sclk  <= 1'b1;
            state_q <= StShiftHi;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        StShiftHi: begin
          if (div_done) begin
            div_q     <= '0;
            o_sclk    <= 1'b0;
            sr1_q     <= sr1_q << 1;
            sr2_q     <= sr2_q << 1;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == BIT_LAST) begin
              o_sdata_1 <= 1'b0;
              o_sdata_2 <= 1'b0;
              o_latch   <= 1'b1;
              state_q   <= StLatch;
            end else begin
              o_sdata_1 <= sr1_q[NBITS-2];
              o_sdata_2 <= sr2_q[NBITS-2];
              state_q   <= StShiftLo;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        StLatch: begin
          if (div_done) begin
            div_q   <= '0;
            o_latch <= 1'b0;
            o_busy  <= 1'b0;
            o_seq   <= seq_q;
            seq_q   <= seq_q + 3'd1;
            state_q <= StIdle;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_feedback_tx.sv
// Self-checking bench for pad_feedback_tx: directed scenarios plus randomized frames
// checked against an arithmetic frame model.
module tb_pad_feedback_tx;

  localparam int CLK_DIV = 4;
`ifdef PAD_TX_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif
  localparam int FLEN = 1 + 2 * CLK_DIV * NBITS + CLK_DIV;

  logic       clk, rst_n, i_send;
  logic [1:0] i_state, i_who_wins;
  logic [4:0] i_p1_shell, i_p2_shell, i_p1_led, i_p2_led;
  logic       o_sclk, o_sdata_1, o_sdata_2, o_latch, o_busy;
  logic [2:0] o_seq;

  pad_feedback_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_send     (i_send),
    .i_state    (i_state),
    .i_who_wins (i_who_wins),
    .i_p1_shell (i_p1_shell),
    .i_p2_shell (i_p2_shell),
    .i_p1_led   (i_p1_led),
    .i_p2_led   (i_p2_led),
    .o_sclk     (o_sclk),
    .o_sdata_1  (o_sdata_1),
    .o_sdata_2  (o_sdata_2),
    .o_latch    (o_latch),
    .o_busy     (o_busy),
    .o_seq      (o_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] d1;
    logic [16:0] d2;
    int          edges;
    int          busy_len;
    int          latch_len;
    int          start;
    int          stop;
    logic [2:0]  seq;
  } rec_t;

  rec_t       cur;
  rec_t       recs[$];
  bit         in_frame;
  logic       prev_sclk;
  int         cyc, latch_total;
  int         n_checks, n_fail;
  int         last_start, last_stop;
  logic [2:0] exp_seq;
  logic [1:0] m_state, m_who;
  logic [4:0] m_p1_shell, m_p2_shell, m_p1_led, m_p2_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pad-side view of the link: collect bits on SCLK rising edges, measure busy/latch.
  task automatic sample();
    if (!rst_n) begin
      in_frame  = 1'b0;
      prev_sclk = 1'b0;
      return;
    end
    cyc++;
    if (o_latch) latch_total++;
    if (o_busy && !in_frame) begin
      in_frame  = 1'b1;
      cur       = '{default: 0};
      cur.start = cyc;
    end
    if (in_frame) begin
      if (o_busy) begin
        cur.busy_len++;
        if (o_latch) cur.latch_len++;
        if (o_sclk && !prev_sclk) begin
          cur.edges++;
          cur.d1 = {cur.d1[15:0], o_sdata_1};
          cur.d2 = {cur.d2[15:0], o_sdata_2};
        end
      end else begin
        cur.stop = cyc;
        cur.seq  = o_seq;
        recs.push_back(cur);
        in_frame = 1'b0;
      end
    end
    prev_sclk = o_sclk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  function automatic logic [16:0] exp_frame(input logic [1:0] st, input logic w,
                                            input logic [4:0] sh, input logic [2:0] sq,
                                            input logic [4:0] led);
    int v;
    v = int'(st) * 16384 + int'(w) * 8192 + int'(sh) * 256 + int'(sq) * 32 + int'(led);
`ifdef PAD_TX_PARITY_EN
    v = v * 2 + ((($countones(v) % 2) == 0) ? 1 : 0);
`endif
    return 17'(v);
  endfunction

  task automatic set_rand();
    i_state    = 2'($urandom);
    i_who_wins = 2'($urandom);
    i_p1_shell = 5'($urandom);
    i_p2_shell = 5'($urandom);
    i_p1_led   = 5'($urandom);
    i_p2_led   = 5'($urandom);
  endtask

  task automatic pulse();
    i_send = 1'b1;
    tick();
    i_send = 1'b0;
  endtask

  // Start a frame from idle: snapshot the inputs into the model and check busy latency.
  task automatic send_frame(input string tag);
    chk({tag, "_idle_before"}, 32'(o_busy), 0);
    m_state    = i_state;
    m_who      = i_who_wins;
    m_p1_shell = i_p1_shell;
    m_p2_shell = i_p2_shell;
    m_p1_led   = i_p1_led;
    m_p2_led   = i_p2_led;
    pulse();
    chk({tag, "_busy_rise"}, 32'(o_busy), 1);
  endtask

  task automatic check_frame(input string tag);
    int   b;
    rec_t r;
    b = 3000;
    while (recs.size() == 0 && b > 0) begin
      tick();
      b--;
    end
    chk({tag, "_done"}, 32'(recs.size() != 0), 1);
    if (recs.size() != 0) begin
      r = recs.pop_front();
      chk({tag, "_sdata_1"}, 32'(r.d1),
          32'(exp_frame(m_state, m_who[0], m_p1_shell, exp_seq, m_p1_led)));
      chk({tag, "_sdata_2"}, 32'(r.d2),
          32'(exp_frame(m_state, m_who[1], m_p2_shell, exp_seq, m_p2_led)));
      chk({tag, "_sclk_edges"}, 32'(r.edges), 32'(NBITS));
      chk({tag, "_busy_len"}, 32'(r.busy_len), 32'(FLEN));
      chk({tag, "_latch_len"}, 32'(r.latch_len), 32'(CLK_DIV));
      chk({tag, "_o_seq"}, 32'(r.seq), 32'(exp_seq));
      last_start = r.start;
      last_stop  = r.stop;
      exp_seq    = exp_seq + 3'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n   = 1'b1;
    exp_seq = '0;
    recs.delete();
    tick();
  endtask

  initial begin
    int stop1, lt0;
    n_checks = 0; n_fail = 0; cyc = 0; latch_total = 0;
    in_frame = 1'b0; prev_sclk = 1'b0; exp_seq = '0;
    i_send = 1'b0;
    i_state = '0; i_who_wins = '0;
    i_p1_shell = '0; i_p2_shell = '0; i_p1_led = '0; i_p2_led = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_sclk", 32'(o_sclk), 0);
    chk("rst_sdata_1", 32'(o_sdata_1), 0);
    chk("rst_sdata_2", 32'(o_sdata_2), 0);
    chk("rst_latch", 32'(o_latch), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_seq", 32'(o_seq), 0);
    rst_n = 1'b1;
    tick();

    // Directed frame content
    i_state = 2'b10; i_who_wins = 2'b01;
    i_p1_shell = 5'b00011; i_p1_led = 5'b10101;
    i_p2_shell = 5'b10000; i_p2_led = 5'b01010;
    send_frame("directed");
    check_frame("directed");

    // Requests at frame cycles 10, 20, 30: exactly one extra frame after one idle cycle
    send_frame("pend");
    repeat (3) begin
      repeat (9) tick();
      pulse();
    end
    check_frame("pend1");
    stop1 = last_stop;
    check_frame("pend2");
    chk("pend_gap", 32'(last_start - stop1), 1);
    repeat (300) tick();
    chk("pend_no_third", 32'(recs.size()), 0);
    chk("pend_idle", 32'(o_busy), 0);

    // Nine back-to-back random frames from reset; the ninth wraps to seq 0
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_rand();
      send_frame("rand");
      tick();
      set_rand();
      check_frame("rand");
    end
    chk("wrap_o_seq", 32'(o_seq), 0);

    // Reset in the middle of bit 7 aborts the frame with no latch pulse
    set_rand();
    send_frame("abort");
    repeat (58) tick();
    lt0   = latch_total;
    rst_n = 1'b0;
    #1;
    chk("abort_sclk", 32'(o_sclk), 0);
    chk("abort_sdata_1", 32'(o_sdata_1), 0);
    chk("abort_sdata_2", 32'(o_sdata_2), 0);
    chk("abort_latch", 32'(o_latch), 0);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_seq", 32'(o_seq), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    exp_seq = '0;
    repeat (200) tick();
    chk("abort_no_latch", 32'(latch_total - lt0), 0);
    chk("abort_no_record", 32'(recs.size()), 0);
    set_rand();
    send_frame("post_abort");
    tick();
    set_rand();
    check_frame("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
